reg_wb_queue: RTL and testbench

Write-back queue feeding the register file's single write port (`writeA3`, `data`, `we`). It accepts results from two producers, the ALU (port A) and the load unit (port L), through valid/ready handshakes. Results are buffered in program order in a small FIFO and drained at one register write per cycle. An optional lookup lets the operand-read stage forward results that are queued but not yet written.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_fifo.sv | 72 +++++++
 rtl/reg_wb_queue.sv | 103 ++++++++++
 tb/tb_reg_wb_queue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared widths and entry payload for the register write-back queue.
package wb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry write-back storage: up to two pushes (slot 0 older) and one pop per cycle.
// Exposes the raw entry array, occupancy mask and read pointer for the forwarding search.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push0,
    input  wb_entry_t              entry0,
    input  logic                   push1,
    input  wb_entry_t              entry1,
    input  logic                   pop,
    output wb_entry_t              head,
    output logic [CW-1:0]          count,
    output logic [PW-1:0]          rd_ptr,
    output wb_entry_t [DEPTH-1:0]  entries,
    output logic [DEPTH-1:0]       occ
);

    wb_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         wr_ptr_p1;

    assign wr_ptr_p1 = wr_ptr + PW'(1);
    assign head      = mem[rd_ptr];
    assign entries   = mem;

    // Pointers and occupancy; pointer arithmetic wraps because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    // Storage carries no reset; only occupied slots are ever observed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (push0) begin
                mem[wr_ptr] <= entry0;
                if (push1) begin
                    mem[wr_ptr_p1] <= entry1;
                end
            end else if (push1) begin
                mem[wr_ptr] <= entry1;
            end
        end
    end

    // A slot is occupied when its age relative to the head is below count.
    always_comb begin
        logic [PW-1:0] age;
        age = '0;
        occ = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            age    = PW'(k) - rd_ptr;
            occ[k] = CW'(age) < count;
        end
    end

endmodule

// File: rtl/reg_wb_queue.sv
// Write-back queue in front of the register file write port (ALU + load producers).
// Define WB_FWD_EN to build the youngest-first forwarding lookup; otherwise fwd outputs are 0.
module reg_wb_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        l_valid,
    input  logic [4:0]  l_addr,
    input  logic [31:0] l_data,
    output logic        l_ready,
    output logic [4:0]  writeA3,
    output logic [31:0] data,
    output logic        we,
    input  logic [4:0]  readA1,
    input  logic [4:0]  readA2,
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [31:0] fwd1_data,
    output logic [31:0] fwd2_data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                  a_push;
    logic                  l_push;
    logic                  nonempty;
    wb_entry_t             head;
    logic [CW-1:0]         count;
    logic [PW-1:0]         rd_ptr;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      occ;

    // Readiness depends on registered occupancy only; the load needs two free slots.
    assign a_ready = count <= CW'(DEPTH - 1);
    assign l_ready = count <= CW'(DEPTH - 2);

    // Writes to x0 complete the handshake but are never stored.
    assign a_push = a_valid && a_ready && (a_addr != '0);
    assign l_push = l_valid && l_ready && (l_addr != '0);

    assign nonempty = count != '0;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push0   (a_push),
        .entry0  ('{addr: a_addr, data: a_data}),
        .push1   (l_push),
        .entry1  ('{addr: l_addr, data: l_data}),
        .pop     (nonempty),
        .head    (head),
        .count   (count),
        .rd_ptr  (rd_ptr),
        .entries (entries),
        .occ     (occ)
    );

    // Head drives the register file every non-empty cycle; suppressed while reset is held.
    assign we      = nonempty && !rst;
    assign writeA3 = we ? head.addr : '0;
    assign data    = we ? head.data : '0;

`ifdef WB_FWD_EN
    // Walk oldest to youngest so the last match (youngest) wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        fwd1_hit  = 1'b0;
        fwd2_hit  = 1'b0;
        fwd1_data = '0;
        fwd2_data = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            idx = rd_ptr + PW'(j);
            if (occ[idx]) begin
                if ((readA1 != '0) && (entries[idx].addr == readA1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = entries[idx].data;
                end
                if ((readA2 != '0) && (entries[idx].addr == readA2)) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = entries[idx].data;
                end
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{readA1, readA2, entries, occ, rd_ptr};
    assign fwd1_hit   = 1'b0;
    assign fwd2_hit   = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_data  = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Table-driven bench for reg_wb_queue with a scoreboard of expected register writes.
module tb_reg_wb_queue;
    import wb_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, l_valid;
    logic [4:0]  a_addr, l_addr;
    logic [31:0] a_data, l_data;
    logic        a_ready, l_ready;
    logic [4:0]  writeA3;
    logic [31:0] data;
    logic        we;
    logic [4:0]  readA1, readA2;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;

    int errors = 0;
    int checks = 0;
    wb_entry_t sb[$];

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        ar;
        logic        lr;
    } vec_t;

    vec_t tbl[17];

    reg_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .l_valid   (l_valid),
        .l_addr    (l_addr),
        .l_data    (l_data),
        .l_ready   (l_ready),
        .writeA3   (writeA3),
        .data      (data),
        .we        (we),
        .readA1    (readA1),
        .readA2    (readA2),
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd1_data (fwd1_data),
        .fwd2_data (fwd2_data)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int av, input int aa, input int ad,
                                input int lv, input int la, input int ld,
                                input int ar, input int lr);
        vec_t m;
        m.av = (av != 0);
        m.aa = 5'(aa);
        m.ad = 32'(ad);
        m.lv = (lv != 0);
        m.la = 5'(la);
        m.ld = 32'(ld);
        m.ar = (ar != 0);
        m.lr = (lr != 0);
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Youngest queued match for a read address (lookup disabled -> always miss).
    task automatic fwd_model(input logic [4:0] ra, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
`ifdef WB_FWD_EN
        foreach (sb[i]) begin
            if (ra != '0 && sb[i].addr == ra) begin
                hit = 1'b1;
                d   = sb[i].data;
            end
        end
`endif
    endtask

    task automatic check_outputs(input string tag, input logic ar, input logic lr);
        wb_entry_t   e;
        logic        h;
        logic [31:0] d;
        fwd_model(readA1, h, d);
        chk({tag, " fwd1_hit"}, 32'(fwd1_hit), 32'(h));
        chk({tag, " fwd1_data"}, fwd1_data, d);
        fwd_model(readA2, h, d);
        chk({tag, " fwd2_hit"}, 32'(fwd2_hit), 32'(h));
        chk({tag, " fwd2_data"}, fwd2_data, d);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " we"}, 32'(we), 32'd1);
            chk({tag, " writeA3"}, 32'(writeA3), 32'(e.addr));
            chk({tag, " data"}, data, e.data);
        end else begin
            chk({tag, " we"}, 32'(we), 32'd0);
            chk({tag, " writeA3"}, 32'(writeA3), 32'd0);
            chk({tag, " data"}, data, 32'd0);
        end
        chk({tag, " a_ready"}, 32'(a_ready), 32'(ar));
        chk({tag, " l_ready"}, 32'(l_ready), 32'(lr));
    endtask

    // Check current outputs, then present one cycle of stimulus and book accepted entries.
    task automatic step(input string tag, input vec_t v);
        check_outputs(tag, v.ar, v.lr);
        a_valid = v.av; a_addr = v.aa; a_data = v.ad;
        l_valid = v.lv; l_addr = v.la; l_data = v.ld;
        if (v.av && v.ar && v.aa != '0) sb.push_back('{addr: v.aa, data: v.ad});
        if (v.lv && v.lr && v.la != '0) sb.push_back('{addr: v.la, data: v.ld});
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        l_valid = 1'b0;
    endtask

    initial begin
        tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,        1, 1);
        tbl[1]  = mk(0, 0, 0,            0, 0, 0,        1, 1);
        tbl[2]  = mk(0, 0, 0,            0, 0, 0,        1, 1);
        tbl[3]  = mk(1, 0, 32'hFF,       0, 0, 0,        1, 1);
        tbl[4]  = mk(0, 0, 0,            0, 0, 0,        1, 1);
        tbl[5]  = mk(1, 3, 32'h11,       1, 3, 32'h22,   1, 1);
        tbl[6]  = mk(0, 0, 0,            0, 0, 0,        1, 1);
        tbl[7]  = mk(0, 0, 0,            0, 0, 0,        1, 1);
        tbl[8]  = mk(1, 1, 32'h101,      1, 2, 32'h102,  1, 1);
        tbl[9]  = mk(1, 3, 32'h103,      1, 4, 32'h104,  1, 1);
        tbl[10] = mk(1, 5, 32'h105,      1, 6, 32'h106,  1, 0);
        tbl[11] = mk(1, 7, 32'h107,      1, 6, 32'h106,  1, 0);
        tbl[12] = mk(0, 0, 0,            1, 6, 32'h106,  1, 0);
        tbl[13] = mk(0, 0, 0,            1, 6, 32'h106,  1, 1);
        tbl[14] = mk(0, 0, 0,            0, 0, 0,        1, 1);
        tbl[15] = mk(0, 0, 0,            0, 0, 0,        1, 1);
        tbl[16] = mk(0, 0, 0,            0, 0, 0,        1, 1);

        rst = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        l_valid = 1'b0; l_addr = '0; l_data = '0;
        readA1 = 5'd3;
        readA2 = 5'd6;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset we", 32'(we), 32'd0);
        chk("reset writeA3", 32'(writeA3), 32'd0);
        chk("reset data", data, 32'd0);
        chk("reset a_ready", 32'(a_ready), 32'd1);
        chk("reset l_ready", 32'(l_ready), 32'd1);

        for (int i = 0; i < 17; i++) step($sformatf("row%0d", i), tbl[i]);

        // Two same-address entries queued: lookup must return the younger one.
        readA1 = 5'd7;
        readA2 = 5'd0;
        step("fwd push", mk(1, 7, 32'h1, 1, 7, 32'h2, 1, 1));
        step("fwd q2", mk(0, 0, 0, 0, 0, 0, 1, 1));
        step("fwd q1", mk(0, 0, 0, 0, 0, 0, 1, 1));
        step("fwd empty", mk(0, 0, 0, 0, 0, 0, 1, 1));

        // Reset with three entries queued drops them all.
        step("rst fill0", mk(1, 1, 32'hA1, 1, 2, 32'hA2, 1, 1));
        step("rst fill1", mk(1, 3, 32'hA3, 1, 4, 32'hA4, 1, 1));
        rst = 1'b1;
        #1;
        chk("rst cycle we", 32'(we), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        sb.delete();
        chk("post rst we", 32'(we), 32'd0);
        chk("post rst writeA3", 32'(writeA3), 32'd0);
        chk("post rst a_ready", 32'(a_ready), 32'd1);
        chk("post rst l_ready", 32'(l_ready), 32'd1);
        step("post rst push", mk(1, 9, 32'h99, 0, 0, 0, 1, 1));
        step("post rst wr", mk(0, 0, 0, 0, 0, 0, 1, 1));
        step("post rst idle", mk(0, 0, 0, 0, 0, 0, 1, 1));

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
